postbox_link_sched: RTL and testbench

//  Sits between the POST-box pulse-protocol engine (postcode) and the byte-level clients.

---
 rtl/postbox_pkg.sv | 14 +
 rtl/postbox_pulse_sync.sv | 27 ++
 rtl/postbox_link_sched.sv | 159 +++++++++++++++
 tb/tb_postbox_link_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/postbox_pkg.sv
// rtl/postbox_pkg.sv - shared types and default parameters for the POST-box link scheduler
package postbox_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_OFFER = 2'd1,
    TX_ACK   = 2'd2
  } tx_state_t;

  localparam int DEF_RX_DEPTH    = 16;
  localparam int DEF_RX_AW       = 4;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/postbox_pulse_sync.sv
// rtl/postbox_pulse_sync.sv - synchroniser chain plus rising-edge detector for an async strobe
module postbox_pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic pulse
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], strobe};
      prev  <= chain[STAGES-1];
    end
  end

  // One pulse per rising edge, however long the strobe stays high
  assign pulse = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/postbox_link_sched.sv
// rtl/postbox_link_sched.sv - round-robin INPUT byte arbiter and OUTPUT byte FIFO for the postcode engine
module postbox_link_sched
  import postbox_pkg::*;
#(
  parameter int RX_DEPTH    = DEF_RX_DEPTH,
  parameter int RX_AW       = DEF_RX_AW,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic [7:0] pc_rxdata,
  input  logic       pc_rxstrobe,
  output logic       pc_rxready,
  output logic [7:0] pc_txdata,
  output logic       pc_txpending,
  input  logic       pc_txdone,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ack,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_pop,
  output logic       rx_overflow,
  output logic       tx_owner
);

  localparam logic [RX_AW:0] CNT_FULL      = (RX_AW+1)'(RX_DEPTH);
  localparam logic [RX_AW:0] CNT_READY_MAX = (RX_AW+1)'(RX_DEPTH - 2);

  logic rx_evt;
  logic txdone_evt;

  postbox_pulse_sync #(.STAGES(SYNC_STAGES)) u_rx_sync (
    .clk    (refclk),
    .rst    (reset),
    .strobe (pc_rxstrobe),
    .pulse  (rx_evt)
  );

  postbox_pulse_sync #(.STAGES(SYNC_STAGES)) u_txdone_sync (
    .clk    (refclk),
    .rst    (reset),
    .strobe (pc_txdone),
    .pulse  (txdone_evt)
  );

  logic [7:0]       mem [RX_DEPTH];
  logic [RX_AW-1:0] wr_ptr;
  logic [RX_AW-1:0] rd_ptr;
  logic [RX_AW:0]   count;
  logic             fifo_full;
  logic             pop_ok;
  logic             push_ok;

  assign fifo_full = (count == CNT_FULL);
  assign rx_valid  = (count != '0);
  assign pop_ok    = rx_pop & rx_valid;
  // A full FIFO still takes a byte when the head leaves in the same cycle
  assign push_ok   = rx_evt & (~fifo_full | pop_ok);

  always_ff @(posedge refclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= pc_rxdata;
    end
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + RX_AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + RX_AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (RX_AW+1)'(1);
        2'b01:   count <= count - (RX_AW+1)'(1);
        default: count <= count;
      endcase
      if (rx_evt && !push_ok) begin
        rx_overflow <= 1'b1;
      end
    end
  end

  assign rx_data    = rx_valid ? mem[rd_ptr] : 8'h00;
  // Ready drops one entry early so a strobe already in the synchroniser still fits
  assign pc_rxready = ~reset & (count <= CNT_READY_MAX);

  tx_state_t  state;
  tx_state_t  state_next;
  logic       last_served;
  logic       grant_id;
  logic       any_valid;
  logic [7:0] hold_data;

  assign any_valid = req0_valid | req1_valid;

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_served;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state <= TX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (any_valid) state_next = TX_OFFER;
      TX_OFFER: if (txdone_evt) state_next = TX_ACK;
      TX_ACK:   state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    pc_txpending = (state == TX_OFFER);
    req0_ack     = (state == TX_ACK) && !tx_owner;
    req1_ack     = (state == TX_ACK) &&  tx_owner;
  end

  // Reset leaves last_served on req1 so req0 wins the first contested grant
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      tx_owner    <= 1'b0;
      last_served <= 1'b1;
      hold_data   <= 8'h00;
    end else begin
      if (state == TX_IDLE && any_valid) begin
        tx_owner  <= grant_id;
        hold_data <= grant_id ? req1_data : req0_data;
      end
      if (state == TX_ACK) begin
        last_served <= tx_owner;
      end
    end
  end

  assign pc_txdata = hold_data;

endmodule

// File: tb/tb_postbox_link_sched.sv
// tb/tb_postbox_link_sched.sv - directed self-checking bench for postbox_link_sched
`timescale 1ns/1ps
module tb_postbox_link_sched;

  logic       refclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc_rxdata = 8'h00;
  logic       pc_rxstrobe = 1'b0;
  logic       pc_rxready;
  logic [7:0] pc_txdata;
  logic       pc_txpending;
  logic       pc_txdone = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_valid = 1'b0;
  logic       req0_ack;
  logic [7:0] req1_data = 8'h00;
  logic       req1_valid = 1'b0;
  logic       req1_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop = 1'b0;
  logic       rx_overflow;
  logic       tx_owner;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #250 refclk = ~refclk;

  postbox_link_sched dut (
    .refclk       (refclk),
    .reset        (reset),
    .pc_rxdata    (pc_rxdata),
    .pc_rxstrobe  (pc_rxstrobe),
    .pc_rxready   (pc_rxready),
    .pc_txdata    (pc_txdata),
    .pc_txpending (pc_txpending),
    .pc_txdone    (pc_txdone),
    .req0_data    (req0_data),
    .req0_valid   (req0_valid),
    .req0_ack     (req0_ack),
    .req1_data    (req1_data),
    .req1_valid   (req1_valid),
    .req1_ack     (req1_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_pop       (rx_pop),
    .rx_overflow  (rx_overflow),
    .tx_owner     (tx_owner)
  );

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    pc_rxstrobe = 1'b0;
    pc_txdone = 1'b0;
    rx_pop = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic rx_byte(input logic [7:0] d);
    pc_rxdata = d;
    pc_rxstrobe = 1'b1;
    repeat (3) tick();
    pc_rxstrobe = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    total_cnt++;
    if ({pc_rxready, pc_txpending, req0_ack, req1_ack, rx_valid, rx_overflow, tx_owner} !== 7'b0) begin
      $display("FAIL reset_ctrl got %b expected 0000000",
               {pc_rxready, pc_txpending, req0_ack, req1_ack, rx_valid, rx_overflow, tx_owner});
    end else pass_cnt++;
    total_cnt++;
    if ({pc_txdata, rx_data} !== 16'h0000) begin
      $display("FAIL reset_data got %h expected 0000", {pc_txdata, rx_data});
    end else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++;
    if (pc_rxready !== 1'b1) begin
      $display("FAIL rxready_after_reset got %b expected 1", pc_rxready);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_offer();
    int acks;
    do_reset();
    rx_byte(8'h77);
    req0_data = 8'h3C;
    req0_valid = 1'b1;
    tick();
    total_cnt++;
    if (pc_txpending !== 1'b1) begin
      $display("FAIL mid_offer_pending got %b expected 1", pc_txpending);
    end else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++;
    if ({pc_txpending, rx_valid, req0_ack} !== 3'b000) begin
      $display("FAIL mid_offer_reset got %b expected 000", {pc_txpending, rx_valid, req0_ack});
    end else pass_cnt++;
    tick();
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (req0_ack === 1'b1) acks++;
    end
    total_cnt++;
    if (acks !== 0) begin
      $display("FAIL mid_offer_no_ack got %0d acks expected 0", acks);
    end else pass_cnt++;
    req0_valid = 1'b0;
  endtask

  task automatic test_single_req0();
    int acks;
    do_reset();
    req0_data = 8'hA5;
    req0_valid = 1'b1;
    tick();
    total_cnt++;
    if ({pc_txpending, pc_txdata, tx_owner} !== {1'b1, 8'hA5, 1'b0}) begin
      $display("FAIL single_offer got pend=%b data=%h owner=%b expected 1 a5 0",
               pc_txpending, pc_txdata, tx_owner);
    end else pass_cnt++;
    pc_txdone = 1'b1;
    acks = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) pc_txdone = 1'b0;
      if (req0_ack === 1'b1) acks++;
      total_cnt++;
      if ({req0_ack, req1_ack} !== {(k == 3), 1'b0}) begin
        $display("FAIL single_ack_cycle%0d got %b%b expected %b0", k, req0_ack, req1_ack, (k == 3));
      end else pass_cnt++;
      if (k == 3) req0_valid = 1'b0;
    end
    total_cnt++;
    if ({acks[3:0], pc_txpending} !== {4'd1, 1'b0}) begin
      $display("FAIL single_ack_count got acks=%0d pend=%b expected 1 0", acks, pc_txpending);
    end else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [4];
    bit         found;
    exp_d = '{8'h11, 8'h22, 8'h11, 8'h22};
    do_reset();
    req0_data = 8'h11;
    req1_data = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
        tick();
        if (pc_txpending === 1'b1) found = 1'b1;
      end
      total_cnt++;
      if (!found || pc_txdata !== exp_d[i] || tx_owner !== i[0]) begin
        $display("FAIL rr_offer%0d got found=%b data=%h owner=%b expected 1 %h %b",
                 i, found, pc_txdata, tx_owner, exp_d[i], i[0]);
      end else pass_cnt++;
      pc_txdone = 1'b1;
      found = 1'b0;
      for (int t = 1; t <= 10 && !found; t++) begin
        tick();
        if (t == 2) pc_txdone = 1'b0;
        if (req0_ack === 1'b1 || req1_ack === 1'b1) found = 1'b1;
      end
      pc_txdone = 1'b0;
      total_cnt++;
      if (!found || {req1_ack, req0_ack} !== (i[0] ? 2'b10 : 2'b01)) begin
        $display("FAIL rr_ack%0d got found=%b acks=%b%b expected %b",
                 i, found, req1_ack, req0_ack, (i[0] ? 2'b10 : 2'b01));
      end else pass_cnt++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_rx_fill_overflow();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      rx_byte(8'(i));
      if (i == 14) begin
        total_cnt++;
        if (pc_rxready !== 1'b1) begin
          $display("FAIL fill14_ready got %b expected 1", pc_rxready);
        end else pass_cnt++;
      end
      if (i == 15) begin
        total_cnt++;
        if (pc_rxready !== 1'b0) begin
          $display("FAIL fill15_ready got %b expected 0", pc_rxready);
        end else pass_cnt++;
      end
      if (i == 16) begin
        total_cnt++;
        if ({rx_overflow, rx_valid} !== 2'b01) begin
          $display("FAIL fill16_ovf got %b%b expected 01", rx_overflow, rx_valid);
        end else pass_cnt++;
      end
    end
    total_cnt++;
    if (rx_overflow !== 1'b1) begin
      $display("FAIL fill17_ovf got %b expected 1", rx_overflow);
    end else pass_cnt++;
    for (int i = 1; i <= 16; i++) begin
      total_cnt++;
      if ({rx_valid, rx_data} !== {1'b1, 8'(i)}) begin
        $display("FAIL fill_pop%0d got v=%b d=%h expected 1 %h", i, rx_valid, rx_data, 8'(i));
      end else pass_cnt++;
      rx_pop = 1'b1;
      tick();
      rx_pop = 1'b0;
    end
    total_cnt++;
    if ({rx_valid, rx_overflow, pc_rxready} !== 3'b011) begin
      $display("FAIL fill_drained got %b expected 011", {rx_valid, rx_overflow, pc_rxready});
    end else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b;
    do_reset();
    for (int i = 0; i < 16; i++) rx_byte(8'h20 + 8'(i));
    total_cnt++;
    if ({pc_rxready, rx_overflow} !== 2'b00) begin
      $display("FAIL full_state got %b expected 00", {pc_rxready, rx_overflow});
    end else pass_cnt++;
    pc_rxdata = 8'h99;
    pc_rxstrobe = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (rx_data !== 8'h20) begin
      $display("FAIL full_head got %h expected 20", rx_data);
    end else pass_cnt++;
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    pc_rxstrobe = 1'b0;
    repeat (2) tick();
    total_cnt++;
    if ({rx_overflow, pc_rxready, rx_valid} !== 3'b001) begin
      $display("FAIL full_coincident got %b expected 001", {rx_overflow, pc_rxready, rx_valid});
    end else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      exp_b = (i == 15) ? 8'h99 : 8'h21 + 8'(i);
      total_cnt++;
      if ({rx_valid, rx_data} !== {1'b1, exp_b}) begin
        $display("FAIL full_pop%0d got v=%b d=%h expected 1 %h", i, rx_valid, rx_data, exp_b);
      end else pass_cnt++;
      rx_pop = 1'b1;
      tick();
      rx_pop = 1'b0;
    end
    total_cnt++;
    if (rx_valid !== 1'b0) begin
      $display("FAIL full_empty got %b expected 0", rx_valid);
    end else pass_cnt++;
  endtask

  task automatic test_stray_txdone();
    bit found;
    int acks;
    do_reset();
    pc_txdone = 1'b1;
    repeat (3) tick();
    pc_txdone = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if ({pc_txpending, req0_ack, req1_ack} !== 3'b000) begin
      $display("FAIL stray_idle got %b expected 000", {pc_txpending, req0_ack, req1_ack});
    end else pass_cnt++;
    req1_data = 8'h5A;
    req1_valid = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (pc_txpending === 1'b1) found = 1'b1;
    end
    total_cnt++;
    if (!found || pc_txdata !== 8'h5A || tx_owner !== 1'b1) begin
      $display("FAIL stray_offer got found=%b data=%h owner=%b expected 1 5a 1", found, pc_txdata, tx_owner);
    end else pass_cnt++;
    acks = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (req0_ack === 1'b1 || req1_ack === 1'b1) acks++;
    end
    total_cnt++;
    if ({acks[3:0], pc_txpending} !== {4'd0, 1'b1}) begin
      $display("FAIL stray_no_ack got acks=%0d pend=%b expected 0 1", acks, pc_txpending);
    end else pass_cnt++;
    pc_txdone = 1'b1;
    found = 1'b0;
    for (int t = 1; t <= 10 && !found; t++) begin
      tick();
      if (t == 2) pc_txdone = 1'b0;
      if (req0_ack === 1'b1 || req1_ack === 1'b1) found = 1'b1;
    end
    pc_txdone = 1'b0;
    total_cnt++;
    if (!found || {req1_ack, req0_ack} !== 2'b10) begin
      $display("FAIL stray_real_ack got found=%b acks=%b%b expected 10", found, req1_ack, req0_ack);
    end else pass_cnt++;
    req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_offer();
    test_single_req0();
    test_round_robin();
    test_rx_fill_overflow();
    test_full_push_pop();
    test_stray_txdone();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
